keypad_number_entry: RTL and testbench

//  Scans a 4x4 matrix keypad, debounces it and builds a decimal setpoint from the keys.

---
 rtl/keypad_number_entry_pkg.sv | 55 +++++
 rtl/keypad_number_entry_if.sv | 45 ++++
 rtl/keypad_number_entry_scanner.sv | 105 ++++++++++
 rtl/keypad_number_entry.sv | 212 +++++++++++++++++++++
 tb/tb_keypad_number_entry.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_number_entry_pkg.sv
// ----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad number-entry block:
//   - keypad geometry and the special key codes ('*' and '#')
//   - scan-result encoding passed from the scanner to the debounce FSM
//   - debounce FSM state enum
//   - key_map(): physical (row, col) position to key code
// ----------------------------------------------------------------------------
package keypad_pkg;

   localparam int ROWS = 4;
   localparam int COLS = 4;

   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   // One full-scan result: valid=0 means NONE (no key, or more than one key)
   typedef struct packed {
      logic       valid;
      logic [3:0] code;
   } scan_result_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAND    = 2'd1,
      PRESSED = 2'd2,
      REL     = 2'd3
   } deb_state_t;

   // Keypad legend: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D
   function automatic logic [3:0] key_map(input logic [1:0] i_r, input logic [1:0] i_c);
      logic [3:0] w_code;
      case ({i_r, i_c})
         4'b00_00: w_code = 4'h1;
         4'b00_01: w_code = 4'h2;
         4'b00_10: w_code = 4'h3;
         4'b00_11: w_code = 4'hA;
         4'b01_00: w_code = 4'h4;
         4'b01_01: w_code = 4'h5;
         4'b01_10: w_code = 4'h6;
         4'b01_11: w_code = 4'hB;
         4'b10_00: w_code = 4'h7;
         4'b10_01: w_code = 4'h8;
         4'b10_10: w_code = 4'h9;
         4'b10_11: w_code = 4'hC;
         4'b11_00: w_code = KEY_STAR;
         4'b11_01: w_code = 4'h0;
         4'b11_10: w_code = KEY_HASH;
         4'b11_11: w_code = 4'hD;
         default:  w_code = 4'h0;
      endcase
      return w_code;
   endfunction

endpackage

// File: rtl/keypad_number_entry_if.sv
// ----------------------------------------------------------------------------
// keypad_number_entry_if
// Keypad matrix lines plus the key/entry/commit outputs of keypad_number_entry.
//   row[3:0]      active-low row drive (exactly one bit low)
//   col[3:0]      active-low column sense, asynchronous to clk
//   key_code[3:0] last accepted key code
//   key_strobe    1-cycle pulse per accepted press
//   entry[9:0]    value being typed
//   entry_active  at least one digit is in entry
//   number[9:0]   committed value
//   number_valid  1-cycle pulse when number is updated
// Modports: slave = the keypad_number_entry block, master = keypad / consumer side.
// ----------------------------------------------------------------------------
interface keypad_number_entry_if;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_strobe;
   logic [9:0] entry;
   logic       entry_active;
   logic [9:0] number;
   logic       number_valid;

   modport slave (
      output row,
      input  col,
      output key_code,
      output key_strobe,
      output entry,
      output entry_active,
      output number,
      output number_valid
   );

   modport master (
      input  row,
      output col,
      input  key_code,
      input  key_strobe,
      input  entry,
      input  entry_active,
      input  number,
      input  number_valid
   );
endinterface

// File: rtl/keypad_number_entry_scanner.sv
// ----------------------------------------------------------------------------
// keypad_scanner
// Drives the keypad rows one at a time, synchronizes the column inputs and
// forms one result per full 4-row scan.
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_col[3:0]         raw active-low column sense
//   o_row[3:0]         registered active-low row drive
//   o_scan_done        high on the last cycle of the row-3 dwell
//   o_scan_key_valid   with o_scan_done: exactly one key seen in the scan
//   o_scan_code[3:0]   with o_scan_key_valid: code of that key
// ----------------------------------------------------------------------------
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_BITS = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [3:0] i_col,
   output logic [3:0] o_row,
   output logic       o_scan_done,
   output logic       o_scan_key_valid,
   output logic [3:0] o_scan_code
);

   logic [SCAN_BITS-1:0] r_dwell;
   logic [1:0]           r_row_idx;
   logic [3:0]           r_row;
   logic [3:0]           r_col_s1;
   logic [3:0]           r_col_s2;
   logic [1:0]           r_hits;      // keys seen so far this scan, saturates at 2
   logic [3:0]           r_code;      // code of the first key seen this scan

   logic                 w_dwell_end;
   logic [3:0]           w_low;
   logic [2:0]           w_cnt;
   logic [1:0]           w_col_idx;
   logic [3:0]           w_code_now;
   logic [2:0]           w_sum;
   logic [1:0]           w_hits_sum;

   // Per-row sample decode: how many columns are low and which one
   always_comb begin
      w_dwell_end = (r_dwell == {SCAN_BITS{1'b1}});
      w_low       = ~r_col_s2;
      w_cnt       = 3'd0;
      w_col_idx   = 2'd0;
      for (int i = 0; i < 4; i++) begin
         w_cnt = w_cnt + {2'b00, w_low[i]};
      end
      for (int i = 3; i >= 0; i--) begin
         w_col_idx = w_low[i] ? 2'(i) : w_col_idx;
      end
      w_code_now = key_map(r_row_idx, w_col_idx);
      // Running key count for the scan including this row's sample
      w_sum      = {1'b0, r_hits} + w_cnt;
      w_hits_sum = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
   end

   // Scan result is presented on the sampling cycle of row 3
   always_comb begin
      o_scan_done      = w_dwell_end && (r_row_idx == 2'd3);
      o_scan_key_valid = (w_hits_sum == 2'd1);
      o_scan_code      = (r_hits == 2'd0) ? w_code_now : r_code;
      o_row            = r_row;
   end

   // Row drive, column synchronizer, dwell counter and per-scan accumulation
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dwell   <= {SCAN_BITS{1'b0}};
         r_row_idx <= 2'd0;
         r_row     <= 4'b1110;
         r_col_s1  <= 4'hF;
         r_col_s2  <= 4'hF;
         r_hits    <= 2'd0;
         r_code    <= 4'h0;
      end else begin
         r_col_s1 <= i_col;
         r_col_s2 <= r_col_s1;
         r_dwell  <= r_dwell + {{(SCAN_BITS-1){1'b0}}, 1'b1};
         if (w_dwell_end) begin
            r_row_idx <= r_row_idx + 2'd1;
            r_row     <= {r_row[2:0], r_row[3]};
            if (r_row_idx == 2'd3) begin
               r_hits <= 2'd0;
               r_code <= 4'h0;
            end else begin
               r_hits <= w_hits_sum;
               if ((r_hits == 2'd0) && (w_cnt == 3'd1)) begin
                  r_code <= w_code_now;
               end else begin
                  r_code <= r_code;
               end
            end
         end else begin
            r_row_idx <= r_row_idx;
            r_row     <= r_row;
            r_hits    <= r_hits;
            r_code    <= r_code;
         end
      end
   end

endmodule

// File: rtl/keypad_number_entry.sv
// ----------------------------------------------------------------------------
// keypad_number_entry
// Scans a 4x4 keypad, debounces whole-scan results and builds a decimal
// setpoint: digits append to entry, '*' clears it, '#' commits it to number.
//   clk       system clock
//   reset     asynchronous active-low reset
//   bus       keypad_number_entry_if.slave (row/col lines, key, entry, number)
// ----------------------------------------------------------------------------
module keypad_number_entry
   import keypad_pkg::*;
#(
   parameter int SCAN_BITS      = 16,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int MAX_VALUE      = 1023
) (
   input  logic                  clk,
   input  logic                  reset,
   keypad_number_entry_if.slave  bus
);

   localparam logic [7:0]  DEB_LIM = 8'(DEBOUNCE_SCANS);
   localparam logic [13:0] MAX_T   = 14'(MAX_VALUE);

   logic         w_scan_done;
   scan_result_t w_scan;
   logic [3:0]   w_row;

   deb_state_t   r_state;
   deb_state_t   w_state_nxt;
   logic [7:0]   r_cnt;
   logic [7:0]   w_cnt_nxt;
   logic [7:0]   w_cnt_inc;
   logic [3:0]   r_cand;
   logic [3:0]   w_cand_nxt;
   logic         w_accept;

   logic [3:0]   r_key_code;
   logic         r_key_strobe;
   logic [9:0]   r_entry;
   logic         r_entry_active;
   logic [9:0]   r_number;
   logic         r_number_valid;

   logic [3:0]   w_key_code_nxt;
   logic [9:0]   w_entry_nxt;
   logic         w_entry_active_nxt;
   logic [9:0]   w_number_nxt;
   logic         w_number_valid_nxt;
   logic [13:0]  w_t;

   keypad_scanner #(
      .SCAN_BITS (SCAN_BITS)
   ) u_scanner (
      .i_clk            (clk),
      .i_rst_n          (reset),
      .i_col            (bus.col),
      .o_row            (w_row),
      .o_scan_done      (w_scan_done),
      .o_scan_key_valid (w_scan.valid),
      .o_scan_code      (w_scan.code)
   );

   // Debounce FSM next state; advances only on a scan result
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cand_nxt  = r_cand;
      w_accept    = 1'b0;
      w_cnt_inc   = r_cnt + 8'd1;
      if (w_scan_done) begin
         case (r_state)
            IDLE: begin
               if (w_scan.valid) begin
                  w_cand_nxt = w_scan.code;
                  if (8'd1 >= DEB_LIM) begin
                     w_accept    = 1'b1;
                     w_cnt_nxt   = 8'd0;
                     w_state_nxt = PRESSED;
                  end else begin
                     w_cnt_nxt   = 8'd1;
                     w_state_nxt = CAND;
                  end
               end else begin
                  w_cnt_nxt   = 8'd0;
                  w_state_nxt = IDLE;
               end
            end
            CAND: begin
               if (w_scan.valid && (w_scan.code == r_cand)) begin
                  if (w_cnt_inc >= DEB_LIM) begin
                     w_accept    = 1'b1;
                     w_cnt_nxt   = 8'd0;
                     w_state_nxt = PRESSED;
                  end else begin
                     w_cnt_nxt   = w_cnt_inc;
                     w_state_nxt = CAND;
                  end
               end else if (w_scan.valid) begin
                  // A different key restarts the candidate count
                  w_cand_nxt  = w_scan.code;
                  w_cnt_nxt   = 8'd1;
                  w_state_nxt = CAND;
               end else begin
                  w_cnt_nxt   = 8'd0;
                  w_state_nxt = IDLE;
               end
            end
            PRESSED: begin
               if (w_scan.valid) begin
                  w_state_nxt = PRESSED;
               end else if (8'd1 >= DEB_LIM) begin
                  w_cnt_nxt   = 8'd0;
                  w_state_nxt = IDLE;
               end else begin
                  w_cnt_nxt   = 8'd1;
                  w_state_nxt = REL;
               end
            end
            REL: begin
               if (w_scan.valid) begin
                  w_cnt_nxt   = 8'd0;
                  w_state_nxt = PRESSED;
               end else if (w_cnt_inc >= DEB_LIM) begin
                  w_cnt_nxt   = 8'd0;
                  w_state_nxt = IDLE;
               end else begin
                  w_cnt_nxt   = w_cnt_inc;
                  w_state_nxt = REL;
               end
            end
            default: begin
               w_cnt_nxt   = 8'd0;
               w_state_nxt = IDLE;
            end
         endcase
      end else begin
         w_state_nxt = r_state;
      end
   end

   // Entry/commit datapath: effects of an accepted key
   always_comb begin
      w_key_code_nxt     = r_key_code;
      w_entry_nxt        = r_entry;
      w_entry_active_nxt = r_entry_active;
      w_number_nxt       = r_number;
      w_number_valid_nxt = 1'b0;
      // entry*10 + d without a multiplier; 14 bits hold the worst case 10239
      w_t = {1'b0, r_entry, 3'b000} + {3'b000, r_entry, 1'b0} + {10'd0, w_scan.code};
      if (w_accept) begin
         w_key_code_nxt = w_scan.code;
         if (w_scan.code <= 4'd9) begin
            if (w_t <= MAX_T) begin
               w_entry_nxt        = w_t[9:0];
               w_entry_active_nxt = 1'b1;
            end else begin
               w_entry_nxt = r_entry;
            end
         end else if (w_scan.code == KEY_STAR) begin
            w_entry_nxt        = 10'd0;
            w_entry_active_nxt = 1'b0;
         end else if (w_scan.code == KEY_HASH) begin
            if (r_entry_active) begin
               w_number_nxt       = r_entry;
               w_number_valid_nxt = 1'b1;
               w_entry_nxt        = 10'd0;
               w_entry_active_nxt = 1'b0;
            end else begin
               w_number_nxt = r_number;
            end
         end else begin
            w_entry_nxt = r_entry;
         end
      end else begin
         w_key_code_nxt = r_key_code;
      end
   end

   // FSM and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= IDLE;
         r_cnt          <= 8'd0;
         r_cand         <= 4'h0;
         r_key_code     <= 4'h0;
         r_key_strobe   <= 1'b0;
         r_entry        <= 10'd0;
         r_entry_active <= 1'b0;
         r_number       <= 10'd0;
         r_number_valid <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_cnt          <= w_cnt_nxt;
         r_cand         <= w_cand_nxt;
         r_key_code     <= w_key_code_nxt;
         r_key_strobe   <= w_accept;
         r_entry        <= w_entry_nxt;
         r_entry_active <= w_entry_active_nxt;
         r_number       <= w_number_nxt;
         r_number_valid <= w_number_valid_nxt;
      end
   end

   assign bus.row          = w_row;
   assign bus.key_code     = r_key_code;
   assign bus.key_strobe   = r_key_strobe;
   assign bus.entry        = r_entry;
   assign bus.entry_active = r_entry_active;
   assign bus.number       = r_number;
   assign bus.number_valid = r_number_valid;

endmodule

// File: tb/tb_keypad_number_entry.sv
// ----------------------------------------------------------------------------
// tb_keypad_number_entry
// Directed bench for keypad_number_entry with SCAN_BITS=2 (16-cycle scan) and
// DEBOUNCE_SCANS=2. A keypad model pulls a column low while its key is held
// and that key's row is driven low. Every expected key strobe is pushed to a
// scoreboard queue when the press is driven and popped when the DUT strobes.
// ----------------------------------------------------------------------------
module tb_keypad_number_entry;

   localparam int SCAN = 16;

   typedef struct {
      logic [3:0] code;
      logic [9:0] entry;
      logic       active;
      logic [9:0] number;
      logic       nv;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [15:0] held;
   logic [3:0]  w_col;
   exp_t        sb[$];
   int          tests;
   int          fails;
   int          m_entry;
   logic        m_active;
   int          m_number;

   keypad_number_entry_if bus ();

   keypad_number_entry #(
      .SCAN_BITS      (2),
      .DEBOUNCE_SCANS (2),
      .MAX_VALUE      (1023)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad model: held key (r,c) pulls column c low while row r is driven low
   always_comb begin
      w_col = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (held[r*4+c] && (bus.row[r] == 1'b0)) w_col[c] = 1'b0;
         end
      end
   end
   assign bus.col = w_col;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model of one accepted key; pushes the expected strobe outcome
   task automatic push_key(input logic [3:0] code);
      exp_t e;
      int   t;
      e.nv = 1'b0;
      if (code <= 4'd9) begin
         t = m_entry * 10 + int'(code);
         if (t <= 1023) begin
            m_entry  = t;
            m_active = 1'b1;
         end
      end else if (code == 4'hE) begin
         m_entry  = 0;
         m_active = 1'b0;
      end else if (code == 4'hF) begin
         if (m_active) begin
            m_number = m_entry;
            e.nv     = 1'b1;
            m_entry  = 0;
            m_active = 1'b0;
         end
      end
      e.code   = code;
      e.entry  = 10'(m_entry);
      e.active = m_active;
      e.number = 10'(m_number);
      sb.push_back(e);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Hold key (r,c) for 4 scans, release for 4 scans, all strobes must be consumed
   task automatic press(input int r, input int c, input logic [3:0] code);
      push_key(code);
      held = 16'd1 << (r*4 + c);
      wait_cycles(4*SCAN);
      held = 16'd0;
      wait_cycles(4*SCAN);
      check("strobe_seen", 32'(sb.size()), 32'd0);
   endtask

   // Align to the first cycle of a row-0 dwell
   task automatic sync_scan();
      logic [3:0] prev;
      logic       found;
      found = 1'b0;
      prev  = bus.row;
      for (int i = 0; i < 3*SCAN && !found; i++) begin
         wait_cycles(1);
         if (bus.row === 4'b1110 && prev === 4'b0111) found = 1'b1;
         prev = bus.row;
      end
      check("scan_sync", 32'(found), 32'd1);
   endtask

   // Scoreboard side: every strobe must match the front of the queue
   always @(negedge clk) begin
      exp_t e;
      if (bus.key_strobe === 1'b1) begin
         check("strobe_expected", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("key_code", 32'(bus.key_code), 32'(e.code));
            check("entry", 32'(bus.entry), 32'(e.entry));
            check("entry_active", 32'(bus.entry_active), 32'(e.active));
            check("number", 32'(bus.number), 32'(e.number));
            check("number_valid", 32'(bus.number_valid), 32'(e.nv));
         end
      end
      if (bus.number_valid === 1'b1) begin
         check("nv_with_strobe", 32'(bus.key_strobe), 32'd1);
      end
   end

   initial begin
      tests    = 0;
      fails    = 0;
      m_entry  = 0;
      m_active = 1'b0;
      m_number = 0;
      held     = 16'd0;
      reset    = 1'b0;

      // 1: reset state and row rotation
      wait_cycles(3);
      check("rst_row", 32'(bus.row), 32'hE);
      check("rst_number", 32'(bus.number), 32'd0);
      check("rst_entry", 32'(bus.entry), 32'd0);
      check("rst_strobe", 32'(bus.key_strobe), 32'd0);
      check("rst_nv", 32'(bus.number_valid), 32'd0);
      reset = 1'b1;
      check("row_0", 32'(bus.row), 32'hE);
      wait_cycles(4);
      check("row_1", 32'(bus.row), 32'hD);
      wait_cycles(4);
      check("row_2", 32'(bus.row), 32'hB);
      wait_cycles(4);
      check("row_3", 32'(bus.row), 32'h7);
      wait_cycles(4);
      check("row_wrap", 32'(bus.row), 32'hE);

      // 2: enter 512 and commit
      press(1, 1, 4'h5);
      check("entry_5", 32'(bus.entry), 32'd5);
      press(0, 0, 4'h1);
      press(0, 1, 4'h2);
      check("entry_512", 32'(bus.entry), 32'd512);
      press(3, 2, 4'hF);
      check("number_512", 32'(bus.number), 32'd512);
      check("entry_cleared", 32'(bus.entry), 32'd0);

      // 3: bounce - '7' toggled every half scan, then every other scan
      sync_scan();
      for (int i = 0; i < 3; i++) begin
         held = 16'd1 << 8;
         wait_cycles(SCAN/2);
         held = 16'd0;
         wait_cycles(SCAN/2);
      end
      for (int i = 0; i < 2; i++) begin
         held = 16'd1 << 8;
         wait_cycles(SCAN);
         held = 16'd0;
         wait_cycles(SCAN);
      end
      wait_cycles(4*SCAN);
      check("bounce_entry", 32'(bus.entry), 32'(m_entry));
      check("bounce_key_code", 32'(bus.key_code), 32'hF);

      // 4: range limit
      press(0, 0, 4'h1);
      press(3, 1, 4'h0);
      press(0, 1, 4'h2);
      press(0, 2, 4'h3);
      check("entry_1023", 32'(bus.entry), 32'd1023);
      press(1, 0, 4'h4);
      check("entry_hold_1023", 32'(bus.entry), 32'd1023);
      press(3, 0, 4'hE);
      check("entry_star", 32'(bus.entry), 32'd0);
      press(0, 0, 4'h1);
      press(3, 1, 4'h0);
      press(0, 1, 4'h2);
      press(1, 0, 4'h4);
      check("entry_102", 32'(bus.entry), 32'd102);

      // 5: ambiguous scan and empty commit
      held = 16'b0000_0000_0000_0011;
      wait_cycles(4*SCAN);
      held = 16'd0;
      wait_cycles(4*SCAN);
      check("ambig_entry", 32'(bus.entry), 32'd102);
      check("ambig_code", 32'(bus.key_code), 32'h4);
      press(3, 0, 4'hE);
      press(3, 2, 4'hF);
      check("empty_hash_number", 32'(bus.number), 32'd512);

      // 6: reset while '8' is held, then re-debounce from IDLE
      push_key(4'h8);
      held = 16'd1 << 9;
      wait_cycles(4*SCAN);
      check("eight_strobe", 32'(sb.size()), 32'd0);
      check("eight_entry", 32'(bus.entry), 32'd8);
      reset = 1'b0;
      wait_cycles(2);
      check("mid_rst_row", 32'(bus.row), 32'hE);
      check("mid_rst_entry", 32'(bus.entry), 32'd0);
      check("mid_rst_active", 32'(bus.entry_active), 32'd0);
      check("mid_rst_number", 32'(bus.number), 32'd0);
      check("mid_rst_code", 32'(bus.key_code), 32'd0);
      m_entry  = 0;
      m_active = 1'b0;
      m_number = 0;
      push_key(4'h8);
      reset = 1'b1;
      wait_cycles(SCAN + 4);
      check("no_early_strobe", 32'(sb.size()), 32'd1);
      wait_cycles(3*SCAN);
      check("re_debounce_strobe", 32'(sb.size()), 32'd0);
      held = 16'd0;
      wait_cycles(4*SCAN);
      check("final_entry", 32'(bus.entry), 32'd8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
